// File: rtl/load_store_ctrl.sv
// load_store_ctrl: sequences one load/store transaction between the execute
// stage and the data memory port. Latches the request, issues it on the bus
// with a req/busy handshake, waits for the response (with a watchdog), then
// returns an aligned, zero-extended result as a one-cycle strobe.
module load_store_ctrl #(
    parameter int P_TIMEOUT = 255
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFLUSH,
    // execute-side request
    input  logic        iREQ_VALID,
    output logic        oREQ_BUSY,
    input  logic        iREQ_RW,
    input  logic [31:0] iREQ_ADDR,
    input  logic [31:0] iREQ_DATA,
    input  logic [1:0]  iREQ_ORDER,
    input  logic [3:0]  iREQ_MASK,
    input  logic [1:0]  iREQ_SHIFT,
    // data bus request
    output logic        oDATAIO_REQ,
    input  logic        iDATAIO_BUSY,
    output logic        oDATAIO_RW,
    output logic [31:0] oDATAIO_ADDR,
    output logic [31:0] oDATAIO_DATA,
    output logic [1:0]  oDATAIO_ORDER,
    output logic [3:0]  oDATAIO_MASK,
    // data bus response
    input  logic        iDATAIO_REQ,
    input  logic [31:0] iDATAIO_DATA,
    // result to execute
    output logic        oRESULT_VALID,
    output logic        oRESULT_RW,
    output logic        oRESULT_ERROR,
    output logic [31:0] oRESULT_DATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } state_t;

    // The counter value seen in the last waiting cycle; the watchdog fires on
    // the edge that would take the counter to P_TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(P_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [1:0]  shift;
    logic        accept;
    logic        cnt_clr;
    logic        res_load;
    logic        res_err;

    // Load alignment: pick the addressed lane(s) and zero-extend. A zero mask
    // marks a misaligned half; it still goes to the bus but returns 0.
    function automatic logic [31:0] align_load(input logic [31:0] d,
                                               input logic [1:0]  order,
                                               input logic [3:0]  mask,
                                               input logic [1:0]  sh);
        logic [31:0] r;
        r = d;
        case (order)
            2'd0:    r = {24'h0, d[{sh, 3'b000} +: 8]};
            2'd1:    r = (sh == 2'd0) ? {16'h0, d[15:0]} : {16'h0, d[31:16]};
            default: r = d;
        endcase
        if (mask == 4'h0) r = 32'h0;
        return r;
    endfunction

    // State register.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cnt_clr    = 1'b0;
        res_load   = 1'b0;
        res_err    = 1'b0;
        case (state)
            IDLE: begin
                if (iREQ_VALID && !iFLUSH) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A transfer that coincides with a flush still happens; the
                // flush then acts on the waiting phase and drops the response.
                if (!iDATAIO_BUSY) begin
                    cnt_clr    = 1'b1;
                    state_next = iFLUSH ? DROP : WAIT;
                end else if (iFLUSH) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (iDATAIO_REQ) begin
                    // Response and flush together: nothing left to absorb.
                    res_load   = !iFLUSH;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    res_load   = !iFLUSH;
                    res_err    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = DROP;
                end else if (iFLUSH) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (iDATAIO_REQ || cnt == CNT_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign oREQ_BUSY = (state != IDLE);

    // Watchdog counter: runs while a response is outstanding or being dropped.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET)                        cnt <= 8'h0;
        else if (cnt_clr)                    cnt <= 8'h0;
        else if (state == WAIT || state == DROP) cnt <= cnt + 8'h1;
    end

    // Request latch and registered bus request.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            oDATAIO_REQ   <= 1'b0;
            oDATAIO_RW    <= 1'b0;
            oDATAIO_ADDR  <= 32'h0;
            oDATAIO_DATA  <= 32'h0;
            oDATAIO_ORDER <= 2'h0;
            oDATAIO_MASK  <= 4'h0;
            shift         <= 2'h0;
        end else begin
            oDATAIO_REQ <= (state_next == ISSUE);
            if (accept) begin
                oDATAIO_RW    <= iREQ_RW;
                oDATAIO_ADDR  <= iREQ_ADDR;
                oDATAIO_DATA  <= iREQ_DATA;
                oDATAIO_ORDER <= iREQ_ORDER;
                oDATAIO_MASK  <= iREQ_MASK;
                shift         <= iREQ_SHIFT;
            end
        end
    end

    // Result register: one-cycle strobe; fields hold until the next result.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            oRESULT_VALID <= 1'b0;
            oRESULT_RW    <= 1'b0;
            oRESULT_ERROR <= 1'b0;
            oRESULT_DATA  <= 32'h0;
        end else begin
            oRESULT_VALID <= res_load;
            if (res_load) begin
                oRESULT_RW    <= oDATAIO_RW;
                oRESULT_ERROR <= res_err;
                oRESULT_DATA  <= (res_err || oDATAIO_RW) ? 32'h0 :
                                 align_load(iDATAIO_DATA, oDATAIO_ORDER,
                                            oDATAIO_MASK, shift);
            end
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: inputs are driven and outputs sampled
// on the falling edge; every expected value is written out by hand.
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_busy;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_order;
    logic [3:0]  req_mask;
    logic [1:0]  req_shift;
    logic        dio_req;
    logic        dio_busy;
    logic        dio_rw;
    logic [31:0] dio_addr;
    logic [31:0] dio_data;
    logic [1:0]  dio_order;
    logic [3:0]  dio_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        res_valid;
    logic        res_rw;
    logic        res_err;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_ctrl #(.P_TIMEOUT(8)) dut (
        .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(flush),
        .iREQ_VALID(req_valid), .oREQ_BUSY(req_busy), .iREQ_RW(req_rw),
        .iREQ_ADDR(req_addr), .iREQ_DATA(req_data), .iREQ_ORDER(req_order),
        .iREQ_MASK(req_mask), .iREQ_SHIFT(req_shift),
        .oDATAIO_REQ(dio_req), .iDATAIO_BUSY(dio_busy), .oDATAIO_RW(dio_rw),
        .oDATAIO_ADDR(dio_addr), .oDATAIO_DATA(dio_data),
        .oDATAIO_ORDER(dio_order), .oDATAIO_MASK(dio_mask),
        .iDATAIO_REQ(rsp_valid), .iDATAIO_DATA(rsp_data),
        .oRESULT_VALID(res_valid), .oRESULT_RW(res_rw),
        .oRESULT_ERROR(res_err), .oRESULT_DATA(res_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] order, input logic [3:0] mask, input logic [1:0] sh);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_data  = data;
        req_order = order;
        req_mask  = mask;
        req_shift = sh;
    endtask

    // Full transaction from a falling edge in IDLE: request is held for
    // busy_cycles+1 cycles with constant fields, response one cycle after the
    // transfer, result strobe checked for position, contents and width.
    task automatic txn(input string tag, input logic rw, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] order, input logic [3:0] mask,
                       input logic [1:0] sh, input int busy_cycles,
                       input logic [31:0] resp, input logic [31:0] exp);
        drive_req(rw, addr, data, order, mask, sh);
        for (int k = 0; k <= busy_cycles; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk({tag, "/dio_req"},   32'(dio_req), 32'd1);
            chk({tag, "/dio_addr"},  dio_addr, addr);
            chk({tag, "/dio_data"},  dio_data, data);
            chk({tag, "/dio_rw"},    32'(dio_rw), 32'(rw));
            chk({tag, "/dio_order"}, 32'(dio_order), 32'(order));
            chk({tag, "/dio_mask"},  32'(dio_mask), 32'(mask));
            chk({tag, "/req_busy"},  32'(req_busy), 32'd1);
            dio_busy = (k < busy_cycles);
        end
        @(negedge clk);
        chk({tag, "/req_drop"}, 32'(dio_req), 32'd0);
        chk({tag, "/no_early"}, 32'(res_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = resp;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk({tag, "/res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "/res_rw"},    32'(res_rw), 32'(rw));
        chk({tag, "/res_err"},   32'(res_err), 32'd0);
        chk({tag, "/res_data"},  res_data, exp);
        chk({tag, "/idle"},      32'(req_busy), 32'd0);
        @(negedge clk);
        chk({tag, "/one_shot"},  32'(res_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
        req_addr = 32'h0; req_data = 32'h0; req_order = 2'h0; req_mask = 4'h0;
        req_shift = 2'h0; dio_busy = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst/dio_req",   32'(dio_req), 32'd0);
        chk("rst/res_valid", 32'(res_valid), 32'd0);
        chk("rst/res_rw",    32'(res_rw), 32'd0);
        chk("rst/res_err",   32'(res_err), 32'd0);
        chk("rst/res_data",  res_data, 32'h0);
        chk("rst/dio_addr",  dio_addr, 32'h0);
        chk("rst/dio_mask",  32'(dio_mask), 32'h0);
        chk("rst/req_busy",  32'(req_busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loads of every order, and a store stretched by bus busy
        txn("LD8",   1'b0, 32'h1003, 32'h0, 2'd0, 4'b1000, 2'd3, 0, 32'hAABBCCDD, 32'h000000AA);
        txn("LD8s1", 1'b0, 32'h1001, 32'h0, 2'd0, 4'b0010, 2'd1, 0, 32'h12345678, 32'h00000056);
        txn("LD16",  1'b0, 32'h1002, 32'h0, 2'd1, 4'b1100, 2'd2, 0, 32'h12345678, 32'h00001234);
        txn("LD16l", 1'b0, 32'h1000, 32'h0, 2'd1, 4'b0011, 2'd0, 0, 32'h12345678, 32'h00005678);
        txn("LD32",  1'b0, 32'h1000, 32'h0, 2'd2, 4'b1111, 2'd0, 0, 32'h12345678, 32'h12345678);
        txn("LDmis", 1'b0, 32'h1001, 32'h0, 2'd1, 4'b0000, 2'd1, 0, 32'h12345678, 32'h00000000);
        txn("ST32",  1'b1, 32'h2000, 32'hDEADBEEF, 2'd2, 4'b1111, 2'd0, 4, 32'hFFFFFFFF, 32'h0);

        // Request during flush in IDLE is ignored
        drive_req(1'b0, 32'h3000, 32'h0, 2'd2, 4'hF, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flidle/dio_req",  32'(dio_req), 32'd0);
        chk("flidle/req_busy", 32'(req_busy), 32'd0);

        // Flush while the bus is still busy: no transfer, no result
        drive_req(1'b0, 32'h3000, 32'h0, 2'd2, 4'hF, 2'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("flissue/dio_req", 32'(dio_req), 32'd1);
        dio_busy = 1'b1; flush = 1'b1;
        @(negedge clk);
        dio_busy = 1'b0; flush = 1'b0;
        chk("flissue/dio_drop", 32'(dio_req), 32'd0);
        chk("flissue/idle",     32'(req_busy), 32'd0);
        @(negedge clk);
        chk("flissue/no_res",   32'(res_valid), 32'd0);

        // Flush while waiting: the response is absorbed silently
        drive_req(1'b0, 32'h4000, 32'h0, 2'd2, 4'hF, 2'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flwait/drop_busy", 32'(req_busy), 32'd1);
        rsp_valid = 1'b1; rsp_data = 32'h55555555;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("flwait/no_res", 32'(res_valid), 32'd0);
        chk("flwait/idle",   32'(req_busy), 32'd0);
        txn("after_fl", 1'b0, 32'h4004, 32'h0, 2'd2, 4'hF, 2'd0, 0, 32'hCAFEF00D, 32'hCAFEF00D);

        // Watchdog: transfer at end of cycle T, error strobe in cycle T+9
        drive_req(1'b0, 32'h5000, 32'h0, 2'd2, 4'hF, 2'd0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("to/quiet", 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        chk("to/res_valid", 32'(res_valid), 32'd1);
        chk("to/res_err",   32'(res_err), 32'd1);
        chk("to/res_data",  res_data, 32'h0);
        chk("to/res_rw",    32'(res_rw), 32'd0);
        repeat (3) @(negedge clk);
        chk("to/drop_busy", 32'(req_busy), 32'd1);
        rsp_valid = 1'b1; rsp_data = 32'h11111111;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("to/late_rsp", 32'(res_valid), 32'd0);
        chk("to/idle",     32'(req_busy), 32'd0);

        // Back-to-back: second request held valid, accepted in strobe cycle
        drive_req(1'b0, 32'h6000, 32'h0, 2'd2, 4'hF, 2'd0);
        @(negedge clk);
        drive_req(1'b0, 32'h6002, 32'h0, 2'd1, 4'b1100, 2'd2);
        chk("b2b/busy1", 32'(req_busy), 32'd1);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 32'h89ABCDEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("b2b/res1_valid", 32'(res_valid), 32'd1);
        chk("b2b/res1_data",  res_data, 32'h89ABCDEF);
        chk("b2b/idle_strobe", 32'(req_busy), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b/dio_req2",  32'(dio_req), 32'd1);
        chk("b2b/dio_addr2", dio_addr, 32'h6002);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 32'h89ABCDEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("b2b/res2_valid", 32'(res_valid), 32'd1);
        chk("b2b/res2_data",  res_data, 32'h000089AB);

        // Reset while waiting: everything back to zero, later response ignored
        drive_req(1'b1, 32'h7000, 32'h12121212, 2'd2, 4'hF, 2'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst/dio_req",   32'(dio_req), 32'd0);
        chk("mrst/dio_addr",  dio_addr, 32'h0);
        chk("mrst/dio_data",  dio_data, 32'h0);
        chk("mrst/dio_rw",    32'(dio_rw), 32'd0);
        chk("mrst/res_valid", 32'(res_valid), 32'd0);
        chk("mrst/res_data",  res_data, 32'h0);
        chk("mrst/req_busy",  32'(req_busy), 32'd0);
        rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_data = 32'h33333333;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("mrst/ignored", 32'(res_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_ctrl.md
# load_store_ctrl

Sequencing controller between the execute-stage load/store unit and the data memory port. It accepts one decoded request per transaction: direction, address, store data, order, byte mask and load shift. It drives the request onto the data bus with a req/busy handshake and waits for the bus response. It then aligns and zero-extends load data and returns a one-cycle result, stalling execute while a transaction is outstanding. Flush and a response watchdog are handled here, so the pipe never hangs on a lost response.

## Interface
- P_TIMEOUT, 255: cycles (1–255) to wait for a response before an error result; counter is 8 bits.
- iCLOCK  in  1  core clock; all logic on rising edge.
- inRESET  in  1  synchronous, active-low reset.
- iFLUSH  in  1  pipeline flush; cancels the current transaction's result.
- iREQ_VALID  in  1  request from execute.
- oREQ_BUSY  out  1  1 = request not accepted this cycle.
- iREQ_RW  in  1  0 = load, 1 = store.
- iREQ_ADDR  in  32  byte address.
- iREQ_DATA  in  32  store data, already lane-aligned.
- iREQ_ORDER  in  2  0 = byte, 1 = half, 2 = word.
- iREQ_MASK  in  4  byte enables.
- iREQ_SHIFT  in  2  load lane index (byte units).
- oDATAIO_REQ  out  1  bus request.
- iDATAIO_BUSY  in  1  bus cannot take a request.
- oDATAIO_RW / oDATAIO_ADDR / oDATAIO_DATA / oDATAIO_ORDER / oDATAIO_MASK  out  1/32/32/2/4  latched request fields.
- iDATAIO_REQ  in  1  bus response valid; load data or store acknowledge.
- iDATAIO_DATA  in  32  raw response word.
- oRESULT_VALID  out  1  one-cycle result strobe.
- oRESULT_RW  out  1  direction of the completed transaction.
- oRESULT_ERROR  out  1  timeout.
- oRESULT_DATA  out  32  aligned load data; 0 for stores and errors.

## Operation
- States: IDLE, ISSUE, WAIT, DROP. Reset state is IDLE.
- oREQ_BUSY is combinational: 0 in IDLE only.
- IDLE
  - iREQ_VALID=1 and iFLUSH=0: latch all request fields, go to ISSUE.
  - iREQ_VALID=1 with iFLUSH=1: ignore the request.
- ISSUE
  - oDATAIO_REQ=1, driven from a register.
  - Transfer occurs when iDATAIO_BUSY=0; go to WAIT and clear the counter.
  - iFLUSH=1 before transfer: go to IDLE; no bus transfer, no result.
  - iFLUSH and a transfer in the same cycle: the transfer wins, then behave as a flush in WAIT.
- WAIT
  - Counter increments each cycle.
  - On iDATAIO_REQ: register the result, go to IDLE.
  - Counter reaches P_TIMEOUT with no response: error result (oRESULT_ERROR=1, data 0), go to DROP, clear the counter.
  - iFLUSH=1: go to DROP without clearing the counter; the later response produces no result.
- DROP
  - Absorbs one iDATAIO_REQ with no result, or exits after P_TIMEOUT cycles; goes to IDLE.
- Load alignment on the raw word D, with k = latched shift:
  - Order 0: {24'h0, D[8k+7:8k]}.
  - Order 1: shift 0 gives {16'h0, D[15:0]}; any other shift gives {16'h0, D[31:16]}.
  - Order 2: D.
  - Mask 4'h0 (misaligned half) is still issued; result data is 0.
- Stores: oRESULT_DATA=0 and oRESULT_RW=1.
- iDATAIO_REQ in IDLE or ISSUE is ignored.
- Reset mid-transaction: return to IDLE immediately; any response after reset is ignored.

## Timing
- Reset values:
  - oDATAIO_REQ=0 and oRESULT_VALID=0.
  - oRESULT_RW=0, oRESULT_ERROR=0, oRESULT_DATA=0.
  - All oDATAIO_* fields = 0; counter = 0.
- Request accepted at edge N; oDATAIO_REQ=1 in cycle N+1.
- oDATAIO_* fields are stable from the first cycle oDATAIO_REQ is asserted until the transfer; oDATAIO_REQ drops the cycle after the transfer.
- Response in cycle M gives oRESULT_VALID=1 in cycle M+1 for exactly one cycle.
- Minimum latency from accept to result is 3 cycles (zero-wait bus, response one cycle after transfer).
- The state is IDLE in the oRESULT_VALID cycle, so a new request is accepted that cycle (back-to-back).
- Timeout: error strobe in the cycle after the counter reaches P_TIMEOUT.

## Test plan
- LD8: addr 0x1003, shift 3, mask 4'b1000; response 0xAABBCCDD -> oRESULT_DATA=0x000000AA, RW=0, latency 3 cycles.
- LD16: shift 2; response 0x12345678 -> 0x00001234. LD32 -> 0x12345678. Misaligned half (mask 0) -> 0x00000000.
- ST32: addr 0x2000, data 0xDEADBEEF, iDATAIO_BUSY high for 4 cycles -> oDATAIO_REQ held 5 cycles with constant fields; result RW=1, data 0.
- iFLUSH in ISSUE -> no bus transfer, no result. iFLUSH in WAIT -> response absorbed, no result, next request accepted.
- No response with P_TIMEOUT=8 -> error result 9 cycles after transfer; a response 3 cycles later is absorbed silently.
- Two back-to-back loads, second request held valid -> second accepted in the first result's strobe cycle; reset asserted in WAIT -> all outputs 0 the next cycle.
